// File: rtl/cache_mem_arbiter_pkg.sv
// Shared encodings for the I/D memory-port arbiter: FSM states and grant sides.
package cache_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    function automatic logic other_side(input logic side);
        return ~side;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_arb_rr2.sv
// Two-input round-robin picker: a lone requester wins, a tie goes to the side
// that was not granted last.
module arb_rr2
    import cache_mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant,
    output logic any
);

    always_comb begin
        any   = req_i | req_d;
        grant = GRANT_I;
        if (req_i && req_d) begin
            grant = other_side(last_grant);
        end else if (req_d) begin
            grant = GRANT_D;
        end
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one memory port between the I-side (read-only) and D-side requesters,
// one transaction at a time, with a sticky watchdog for a silent memory.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int AWIDTH    = 32,
    parameter int DWIDTH    = 32,
    parameter int MASKW     = DWIDTH / 8,
    parameter int TO_CYCLES = 255
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [AWIDTH-1:0] i_addr,
    output logic              i_resp_valid,
    output logic [DWIDTH-1:0] i_rdata,
    input  logic              d_req,
    input  logic [AWIDTH-1:0] d_addr,
    input  logic [MASKW-1:0]  d_we,
    input  logic [DWIDTH-1:0] d_wdata,
    output logic              d_resp_valid,
    output logic [DWIDTH-1:0] d_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [MASKW-1:0]  mem_we,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DWIDTH-1:0] mem_resp_data,
    output logic              stall,
    output logic              timeout_err
);

    localparam int WD_W = $clog2(TO_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TO_CYCLES - 1);

    arb_state_t        state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              last_grant_reg, last_grant_next;
    logic [AWIDTH-1:0] addr_reg, addr_next;
    logic [MASKW-1:0]  we_reg, we_next;
    logic [DWIDTH-1:0] wdata_reg, wdata_next;
    logic [WD_W-1:0]   watchdog_reg, watchdog_next;
    logic              timeout_err_reg, timeout_err_next;

    logic              rr_grant;
    logic              rr_any;
    logic              pulse_busy;
    logic              done;
    logic [DWIDTH-1:0] done_data;

    arb_rr2 u_arb (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (last_grant_reg),
        .grant      (rr_grant),
        .any        (rr_any)
    );

    // The cycle carrying a response pulse is never used to arbitrate, so a
    // held req is only seen as a new request in the following IDLE cycle.
    assign pulse_busy = i_resp_valid | d_resp_valid;

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_grant_next  = last_grant_reg;
        addr_next        = addr_reg;
        we_next          = we_reg;
        wdata_next       = wdata_reg;
        watchdog_next    = watchdog_reg;
        timeout_err_next = timeout_err_reg;
        mem_req_valid    = 1'b0;
        done             = 1'b0;
        done_data        = '0;
        case (state_reg)
            ARB_IDLE: begin
                if (rr_any && !pulse_busy) begin
                    grant_next = rr_grant;
                    state_next = ARB_ISSUE;
                    if (rr_grant == GRANT_D) begin
                        addr_next  = d_addr;
                        we_next    = d_we;
                        wdata_next = d_wdata;
                    end else begin
                        addr_next  = i_addr;
                        we_next    = '0;
                        wdata_next = '0;
                    end
                end
            end
            ARB_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next    = ARB_WAIT;
                    watchdog_next = '0;
                end
            end
            ARB_WAIT: begin
                watchdog_next = watchdog_reg + 1'b1;
                if (mem_resp_valid) begin
                    done            = 1'b1;
                    done_data       = mem_resp_data;
                    last_grant_next = grant_reg;
                    state_next      = ARB_IDLE;
                end else if (watchdog_reg == WD_LAST) begin
                    // Release the requester with zero data rather than hang the core.
                    done             = 1'b1;
                    timeout_err_next = 1'b1;
                    last_grant_next  = grant_reg;
                    state_next       = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ARB_IDLE;
            grant_reg       <= GRANT_I;
            last_grant_reg  <= GRANT_I;
            addr_reg        <= '0;
            we_reg          <= '0;
            wdata_reg       <= '0;
            watchdog_reg    <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_grant_reg  <= last_grant_next;
            addr_reg        <= addr_next;
            we_reg          <= we_next;
            wdata_reg       <= wdata_next;
            watchdog_reg    <= watchdog_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    // One response channel per side; index 0 is GRANT_I, index 1 is GRANT_D.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            localparam logic SIDE = 1'(gi);
            logic              hit;
            logic              resp_valid_reg;
            logic [DWIDTH-1:0] rdata_reg;

            assign hit = done && (grant_reg == SIDE);

            always_ff @(posedge clk) begin
                if (reset) begin
                    resp_valid_reg <= 1'b0;
                    rdata_reg      <= '0;
                end else begin
                    resp_valid_reg <= hit;
                    if (hit) begin
                        rdata_reg <= done_data;
                    end
                end
            end
        end
    endgenerate

    assign i_resp_valid = g_side[0].resp_valid_reg;
    assign i_rdata      = g_side[0].rdata_reg;
    assign d_resp_valid = g_side[1].resp_valid_reg;
    assign d_rdata      = g_side[1].rdata_reg;

    assign mem_addr    = addr_reg;
    assign mem_we      = we_reg;
    assign mem_wdata   = wdata_reg;
    assign timeout_err = timeout_err_reg;
    assign stall       = (i_req & ~i_resp_valid) | (d_req & ~d_resp_valid);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a configurable memory responder;
// each scenario task checks its own expected values inline.
module tb_cache_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_resp_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_resp_valid;
    logic [31:0] d_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        stall;
    logic        timeout_err;

    int checks;
    int failures;

    // memory responder settings (written by the main sequence only)
    int          ready_delay;
    int          resp_delay;
    bit          respond;
    logic [31:0] resp_word;
    int          force_cnt;

    // monitor state
    int cyc;
    int i_pulses;
    int d_pulses;
    int last_i_cyc;
    int last_d_cyc;
    int order_q[$];

    cache_mem_arbiter #(
        .AWIDTH(32), .DWIDTH(32), .MASKW(4), .TO_CYCLES(8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_resp_valid   (i_resp_valid),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_addr         (d_addr),
        .d_we           (d_we),
        .d_wdata        (d_wdata),
        .d_resp_valid   (d_resp_valid),
        .d_rdata        (d_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .stall          (stall),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (i_resp_valid === 1'b1) begin
            i_pulses   <= i_pulses + 1;
            last_i_cyc <= cyc;
            order_q.push_back(0);
        end
        if (d_resp_valid === 1'b1) begin
            d_pulses   <= d_pulses + 1;
            last_d_cyc <= cyc;
            order_q.push_back(1);
        end
    end

    // Memory model: ready after ready_delay ISSUE cycles, response resp_delay
    // cycles into WAIT_RESP (never if respond=0); force_cnt bumps inject a stray response.
    initial begin : mem_model
        bit hs;
        bit sent;
        bit waiting;
        int icnt;
        int wcnt;
        int force_seen;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        waiting = 0; icnt = 0; wcnt = 0; force_seen = 0;
        forever begin
            hs   = (mem_req_valid === 1'b1) && (mem_req_ready === 1'b1);
            sent = (mem_resp_valid === 1'b1);
            @(posedge clk); #1;
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            if (reset === 1'b1) begin
                waiting = 0; icnt = 0;
            end else begin
                if (hs) begin waiting = 1; wcnt = 0; icnt = 0; end
                if (sent) waiting = 0;
                if (mem_req_valid === 1'b1) begin
                    waiting = 0;
                    mem_req_ready = (icnt >= ready_delay);
                    icnt++;
                end else begin
                    icnt = 0;
                    if (waiting) begin
                        if (respond && wcnt == resp_delay) begin
                            mem_resp_valid = 1'b1;
                            mem_resp_data  = resp_word;
                        end
                        wcnt++;
                    end
                end
                if (force_seen != force_cnt) begin
                    force_seen     = force_cnt;
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = 32'hBAD0_BAD0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    // Returns at negedge+1 of the cycle in which the total pulse count reaches target.
    task automatic wait_total(input int target, input int budget, output bit ok);
        int n = 0;
        while ((i_pulses + d_pulses) < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        ok = ((i_pulses + d_pulses) >= target);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({i_resp_valid, d_resp_valid, mem_req_valid, stall, timeout_err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000",
                     {i_resp_valid, d_resp_valid, mem_req_valid, stall, timeout_err});
        end
        checks++;
        if ({i_rdata, d_rdata} !== 64'd0) begin
            failures++;
            $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata});
        end
        checks++;
        if ({mem_addr, mem_we, mem_wdata} !== 68'd0) begin
            failures++;
            $display("FAIL reset_mem_bus got=%h exp=0", {mem_addr, mem_we, mem_wdata});
        end
        repeat (3) step();
        checks++;
        if (mem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_quiet got=%b exp=0", mem_req_valid);
        end
    endtask

    task automatic test_lone_i();
        int t0, ip0, dp0;
        bit ok;
        step();
        ready_delay = 0; resp_delay = 0; respond = 1; resp_word = 32'hDEAD_BEEF;
        i_req = 1'b1; i_addr = 32'h1000_0000;
        t0 = cyc; ip0 = i_pulses; dp0 = d_pulses;
        step();
        checks++;
        if ({mem_req_valid, mem_addr, mem_we} !== {1'b1, 32'h1000_0000, 4'h0}) begin
            failures++;
            $display("FAIL lone_i_issue got=%h exp=%h", {mem_req_valid, mem_addr, mem_we},
                     {1'b1, 32'h1000_0000, 4'h0});
        end
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL lone_i_stall_pending got=%b exp=1", stall);
        end
        wait_total(ip0 + dp0 + 1, 20, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL lone_i_wait got=no_pulse exp=pulse_within_20");
        end
        checks++;
        if (i_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL lone_i_rdata got=%h exp=deadbeef", i_rdata);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL lone_i_stall_at_resp got=%b exp=0", stall);
        end
        checks++;
        if (last_i_cyc - t0 !== 3) begin
            failures++;
            $display("FAIL lone_i_latency got=%0d exp=3", last_i_cyc - t0);
        end
        i_req = 1'b0;
        repeat (3) step();
        checks++;
        if ({i_pulses - ip0, d_pulses - dp0} !== {32'd1, 32'd0}) begin
            failures++;
            $display("FAIL lone_i_pulse_count got=i%0d/d%0d exp=i1/d0", i_pulses - ip0, d_pulses - dp0);
        end
        checks++;
        if ({i_rdata, d_rdata} !== {32'hDEAD_BEEF, 32'h0}) begin
            failures++;
            $display("FAIL lone_i_hold got=%h exp=deadbeef00000000", {i_rdata, d_rdata});
        end
    endtask

    task automatic test_contention();
        int base;
        int s;
        logic [3:0] code;
        bit ok;
        do_reset();
        ready_delay = 0; resp_delay = 0; respond = 1; resp_word = 32'h0000_C0DE;
        i_req = 1'b1; i_addr = 32'h0000_0100;
        d_req = 1'b1; d_addr = 32'h0000_0200; d_we = 4'h0; d_wdata = 32'h0;
        base = i_pulses + d_pulses;
        step();
        checks++;
        if ({mem_req_valid, mem_addr} !== {1'b1, 32'h0000_0200}) begin
            failures++;
            $display("FAIL contention_first_d got=%h exp=%h", {mem_req_valid, mem_addr}, {1'b1, 32'h0000_0200});
        end
        wait_total(base + 4, 60, ok);
        i_req = 1'b0; d_req = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL contention_wait got=%0d exp=4 pulses", i_pulses + d_pulses - base);
        end
        s = order_q.size();
        code = 4'hF;
        if (s >= 4) code = {order_q[s-4][0], order_q[s-3][0], order_q[s-2][0], order_q[s-1][0]};
        checks++;
        if (code !== 4'b1010) begin
            failures++;
            $display("FAIL contention_order got=%b exp=1010 (1=D,0=I)", code);
        end
        step();
    endtask

    task automatic test_d_write();
        int t0, dp0;
        bit ok;
        step();
        ready_delay = 3; resp_delay = 0; respond = 1; resp_word = 32'h0000_0ACC;
        d_req = 1'b1; d_addr = 32'h8000_0010; d_we = 4'b0011; d_wdata = 32'h0000_ABCD;
        t0 = cyc; dp0 = d_pulses;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if ({mem_req_valid, mem_req_ready, mem_addr, mem_we, mem_wdata} !==
                {1'b1, 1'b0, 32'h8000_0010, 4'b0011, 32'h0000_ABCD}) begin
                failures++;
                $display("FAIL write_hold_%0d got=%h exp=%h", k,
                         {mem_req_valid, mem_req_ready, mem_addr, mem_we, mem_wdata},
                         {1'b1, 1'b0, 32'h8000_0010, 4'b0011, 32'h0000_ABCD});
            end
        end
        step();
        checks++;
        if ({mem_req_valid, mem_req_ready} !== 2'b11) begin
            failures++;
            $display("FAIL write_handshake got=%b exp=11", {mem_req_valid, mem_req_ready});
        end
        wait_total(i_pulses + d_pulses + 1, 20, ok);
        checks++;
        if (!ok || d_pulses !== dp0 + 1) begin
            failures++;
            $display("FAIL write_ack got=%0d exp=1 d pulse", d_pulses - dp0);
        end
        checks++;
        if (last_d_cyc - t0 !== 6) begin
            failures++;
            $display("FAIL write_latency got=%0d exp=6", last_d_cyc - t0);
        end
        checks++;
        if (d_rdata !== 32'h0000_0ACC) begin
            failures++;
            $display("FAIL write_ack_data got=%h exp=00000acc", d_rdata);
        end
        d_req = 1'b0; d_we = 4'h0;
        repeat (3) step();
        checks++;
        if (d_pulses !== dp0 + 1) begin
            failures++;
            $display("FAIL write_single_pulse got=%0d exp=1", d_pulses - dp0);
        end
    endtask

    task automatic test_timeout();
        int t0, ip1, dp1;
        bit ok;
        step();
        ready_delay = 0; resp_delay = 0; respond = 0;
        i_req = 1'b1; i_addr = 32'h2000_0000;
        t0 = cyc;
        wait_total(i_pulses + d_pulses + 1, 40, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL timeout_wait got=no_pulse exp=pulse_within_40");
        end
        checks++;
        if (last_i_cyc - t0 !== 10) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=10", last_i_cyc - t0);
        end
        checks++;
        if ({timeout_err, i_rdata} !== {1'b1, 32'h0}) begin
            failures++;
            $display("FAIL timeout_flag_data got=%h exp=100000000", {timeout_err, i_rdata});
        end
        i_req = 1'b0;
        ip1 = i_pulses; dp1 = d_pulses;
        step();
        force_cnt++;
        repeat (5) step();
        checks++;
        if ({i_pulses - ip1, d_pulses - dp1} !== 64'd0) begin
            failures++;
            $display("FAIL timeout_late_resp got=i%0d/d%0d exp=i0/d0", i_pulses - ip1, d_pulses - dp1);
        end
        checks++;
        if (timeout_err !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got=%b exp=1", timeout_err);
        end
        respond = 1;
    endtask

    task automatic test_reset_mid_wait();
        int ip0, dp0;
        bit ok;
        step();
        ready_delay = 0; resp_delay = 0; respond = 0;
        d_req = 1'b1; d_addr = 32'h3000_0000; d_we = 4'h0; d_wdata = 32'h0;
        repeat (3) step();
        checks++;
        if ({mem_req_valid, stall} !== 2'b01) begin
            failures++;
            $display("FAIL midwait_in_wait got=%b exp=01", {mem_req_valid, stall});
        end
        reset = 1'b1; d_req = 1'b0;
        step();
        reset = 1'b0;
        checks++;
        if ({i_resp_valid, d_resp_valid, mem_req_valid, stall, mem_addr, mem_we, mem_wdata, i_rdata, d_rdata} !== 136'd0) begin
            failures++;
            $display("FAIL midwait_outputs_zero got=%h exp=0",
                     {i_resp_valid, d_resp_valid, mem_req_valid, stall, mem_addr, mem_we, mem_wdata, i_rdata, d_rdata});
        end
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL midwait_timeout_cleared got=%b exp=0", timeout_err);
        end
        ip0 = i_pulses; dp0 = d_pulses;
        force_cnt++;
        repeat (5) step();
        checks++;
        if ({i_pulses - ip0, d_pulses - dp0} !== 64'd0) begin
            failures++;
            $display("FAIL midwait_late_resp got=i%0d/d%0d exp=i0/d0", i_pulses - ip0, d_pulses - dp0);
        end
        respond = 1; resp_word = 32'h5555_AAAA;
        i_req = 1'b1; i_addr = 32'h1000_0004;
        wait_total(i_pulses + d_pulses + 1, 20, ok);
        i_req = 1'b0;
        checks++;
        if (!ok || i_rdata !== 32'h5555_AAAA) begin
            failures++;
            $display("FAIL midwait_recover got=%h ok=%0d exp=5555aaaa", i_rdata, ok);
        end
    endtask

    task automatic test_back_to_back();
        int ip0, c1;
        bit ok;
        step();
        ready_delay = 0; resp_delay = 0; respond = 1; resp_word = 32'h0000_0011;
        d_req = 1'b1; d_addr = 32'h4000_0000; d_we = 4'h0; d_wdata = 32'h0;
        ip0 = i_pulses;
        wait_total(i_pulses + d_pulses + 1, 20, ok);
        checks++;
        if (!ok || d_rdata !== 32'h0000_0011) begin
            failures++;
            $display("FAIL b2b_first got=%h ok=%0d exp=00000011", d_rdata, ok);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stall_at_resp got=%b exp=0", stall);
        end
        c1 = last_d_cyc;
        resp_word = 32'h0000_0022;
        wait_total(i_pulses + d_pulses + 1, 20, ok);
        d_req = 1'b0;
        checks++;
        if (!ok || d_rdata !== 32'h0000_0022) begin
            failures++;
            $display("FAIL b2b_second got=%h ok=%0d exp=00000022", d_rdata, ok);
        end
        checks++;
        if (last_d_cyc - c1 !== 4) begin
            failures++;
            $display("FAIL b2b_spacing got=%0d exp=4", last_d_cyc - c1);
        end
        checks++;
        if (i_pulses !== ip0) begin
            failures++;
            $display("FAIL b2b_i_untouched got=%0d exp=0", i_pulses - ip0);
        end
        repeat (3) step();
    endtask

    initial begin
        checks = 0; failures = 0;
        ready_delay = 0; resp_delay = 0; respond = 1; resp_word = '0; force_cnt = 0;
        cyc = 0; i_pulses = 0; d_pulses = 0; last_i_cyc = 0; last_d_cyc = 0;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_we = '0; d_wdata = '0;
        test_reset();
        test_lone_i();
        test_contention();
        test_d_write();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=still_running exp=finished");
        $fatal(1, "time limit");
    end

endmodule
